machine_timer: RTL and testbench

- Memory-mapped RISC-V machine timer (mtime/mtimecmp) plus msip register.
- Sits on the core's data bus, downstream of kronos_core's data_req/data_ack port.
- Drives the core's timer_interrupt and software_interrupt inputs.
- Replaces the currently undriven interrupt sources at the board top level.

---
 rtl/machine_timer.sv | 225 ++++++++++++++++++++++
 tb/tb_machine_timer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// Purpose : RISC-V machine timer (mtime/mtimecmp) and msip register on the core data bus.
// Latency : request accepted in cycle N, data_ack pulses in cycle N+1; timer_interrupt lags mtime by one cycle.
// Backpr. : none; the master holds data_req until data_ack, and unselected requests are never acked.
//
// Ports:
//   clk, rstz            clock and synchronous active-low reset
//   data_addr            byte address; [31:5] selects the window, [4:2] the register, [1:0] ignored
//   data_wr_data         write data, merged per byte under data_mask
//   data_mask            byte-lane enables
//   data_wr_en           1 = write, 0 = read
//   data_req             request, held until data_ack
//   data_ack             one-cycle acknowledge
//   data_rd_data         read data, valid while data_ack = 1, holds otherwise
//   timer_interrupt      registered (mtime >= mtimecmp)
//   software_interrupt   msip[0]
//
// BASE_ADDR must be 32-byte aligned; its low five bits take no part in decode.
// TICK_DIV is the number of clk cycles per mtime increment (1..65536).

module machine_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    // ------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------
    localparam int unsigned     PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [2:0] OFF_MSIP     = 3'd0;
    localparam logic [2:0] OFF_CMP_LO   = 3'd1;
    localparam logic [2:0] OFF_CMP_HI   = 3'd2;
    localparam logic [2:0] OFF_MTIME_LO = 3'd3;
    localparam logic [2:0] OFF_MTIME_HI = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic          msip_q,     msip_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [63:0]   mtime_q,    mtime_d;
    logic [PW-1:0] pre_q,      pre_d;
    logic [31:0]   rd_data_q,  rd_data_d;
    logic          tmr_irq_q,  tmr_irq_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       sel;
    logic       accept;
    logic       wr_acc;
    logic [2:0] off;
    logic       tick;
    logic       mtime_wr;
    logic [31:0] rd_word;

    // Byte-offset bits carry no meaning for word registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^data_addr[1:0];

    // Byte-lane merge: lanes with a set mask bit take the new byte.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        sel      = (data_addr[31:5] == BASE_ADDR[31:5]);
        off      = data_addr[4:2];
        // Requests are only taken in IDLE; data_req is ignored while acking.
        accept   = (state_q == IDLE) && data_req && sel;
        wr_acc   = accept && data_wr_en;
        mtime_wr = wr_acc && ((off == OFF_MTIME_LO) || (off == OFF_MTIME_HI));
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_ack = (state_q == RESP);

    // ------------------------------------------------------------------
    // Prescaler: free-running, never disturbed by bus writes
    // ------------------------------------------------------------------
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // ------------------------------------------------------------------
    // Read path: captures the pre-write register value at the accept edge
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (off)
            OFF_MSIP:     rd_word = {31'd0, msip_q};
            OFF_CMP_LO:   rd_word = mtimecmp_q[31:0];
            OFF_CMP_HI:   rd_word = mtimecmp_q[63:32];
            OFF_MTIME_LO: rd_word = mtime_q[31:0];
            OFF_MTIME_HI: rd_word = mtime_q[63:32];
            default:      rd_word = '0;
        endcase
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (accept) begin
            rd_data_d = data_wr_en ? 32'd0 : rd_word;
        end
    end

    // ------------------------------------------------------------------
    // Register writes and mtime increment
    // ------------------------------------------------------------------
    always_comb begin
        msip_d = msip_q;
        if (wr_acc && (off == OFF_MSIP) && data_mask[0]) begin
            msip_d = data_wr_data[0];
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_acc && (off == OFF_CMP_LO)) begin
            mtimecmp_d[31:0] = lane_merge(mtimecmp_q[31:0], data_wr_data, data_mask);
        end
        if (wr_acc && (off == OFF_CMP_HI)) begin
            mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], data_wr_data, data_mask);
        end
    end

    // A software write to mtime wins over a coincident tick: the unwritten
    // bytes hold and the increment for that tick is dropped.
    always_comb begin
        mtime_d = mtime_q;
        if (mtime_wr) begin
            if (off == OFF_MTIME_LO) begin
                mtime_d[31:0] = lane_merge(mtime_q[31:0], data_wr_data, data_mask);
            end
            if (off == OFF_MTIME_HI) begin
                mtime_d[63:32] = lane_merge(mtime_q[63:32], data_wr_data, data_mask);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Compare uses the values that were registered at the previous edge.
    always_comb begin
        tmr_irq_d = (mtime_q >= mtimecmp_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q    <= IDLE;
            msip_q     <= 1'b0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q    <= 64'd0;
            pre_q      <= '0;
            rd_data_q  <= 32'd0;
            tmr_irq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            pre_q      <= pre_d;
            rd_data_q  <= rd_data_d;
            tmr_irq_q  <= tmr_irq_d;
        end
    end

    assign data_rd_data       = rd_data_q;
    assign timer_interrupt    = tmr_irq_q;
    assign software_interrupt = msip_q;

endmodule

// File: tb/tb_machine_timer.sv
`timescale 1ns/1ps

module tb_machine_timer;

    logic        clk;
    logic        rstz;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;

    logic [1:0]  ack_v;
    logic [31:0] rd_a, rd_b;
    logic [1:0]  tmr_v;
    logic [1:0]  sw_v;

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: TICK_DIV=1 at 0x1000; instance 1: TICK_DIV=4 at 0x3000.
    machine_timer #(.BASE_ADDR(32'h0000_1000), .TICK_DIV(1)) u_a (
        .clk(clk), .rstz(rstz), .data_addr(data_addr), .data_wr_data(data_wr_data),
        .data_mask(data_mask), .data_wr_en(data_wr_en), .data_req(data_req),
        .data_ack(ack_v[0]), .data_rd_data(rd_a),
        .timer_interrupt(tmr_v[0]), .software_interrupt(sw_v[0])
    );

    machine_timer #(.BASE_ADDR(32'h0000_3000), .TICK_DIV(4)) u_b (
        .clk(clk), .rstz(rstz), .data_addr(data_addr), .data_wr_data(data_wr_data),
        .data_mask(data_mask), .data_wr_en(data_wr_en), .data_req(data_req),
        .data_ack(ack_v[1]), .data_rd_data(rd_b),
        .timer_interrupt(tmr_v[1]), .software_interrupt(sw_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input int i);
        return (i == 0) ? rd_a : rd_b;
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? 32'h0000_1000 : 32'h0000_3000;
    endfunction

    function automatic logic [31:0] apply_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] m);
        logic [31:0] keep;
        keep = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (new_v & keep) | (old_v & ~keep);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: architectural registers per instance
    // ------------------------------------------------------------------
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic        m_irq   [2];
    logic        m_ack   [2];
    logic [31:0] m_rd    [2];
    int          m_pre   [2];
    logic        seen_edge = 1'b0;
    int          edge_cnt  = 0;

    logic        mt_tick, mt_acc, mt_irq_next, mt_time_wr;
    logic [31:0] mt_base, mt_word;
    logic [63:0] mt_old_time, mt_old_cmp;

    always @(posedge clk) begin
        seen_edge = 1'b1;
        edge_cnt  = rstz ? edge_cnt + 1 : 0;
        for (int i = 0; i < 2; i++) begin
            if (!rstz) begin
                m_mtime[i] = 64'd0;
                m_cmp[i]   = '1;
                m_msip[i]  = 1'b0;
                m_irq[i]   = 1'b0;
                m_ack[i]   = 1'b0;
                m_rd[i]    = 32'd0;
                m_pre[i]   = 0;
            end else begin
                mt_old_time = m_mtime[i];
                mt_old_cmp  = m_cmp[i];
                mt_tick     = (m_pre[i] == div_of(i) - 1);
                m_pre[i]    = (m_pre[i] + 1) % div_of(i);
                mt_irq_next = (mt_old_time >= mt_old_cmp);
                mt_base     = base_of(i);
                mt_acc      = !m_ack[i] && data_req && (data_addr[31:5] == mt_base[31:5]);
                case (data_addr[4:2])
                    3'd0:    mt_word = {31'd0, m_msip[i]};
                    3'd1:    mt_word = mt_old_cmp[31:0];
                    3'd2:    mt_word = mt_old_cmp[63:32];
                    3'd3:    mt_word = mt_old_time[31:0];
                    3'd4:    mt_word = mt_old_time[63:32];
                    default: mt_word = 32'd0;
                endcase
                mt_time_wr = 1'b0;
                if (mt_acc) begin
                    m_rd[i] = data_wr_en ? 32'd0 : mt_word;
                    if (data_wr_en) begin
                        case (data_addr[4:2])
                            3'd0: if (data_mask[0]) m_msip[i] = data_wr_data[0];
                            3'd1: m_cmp[i][31:0]  = apply_lanes(mt_old_cmp[31:0], data_wr_data, data_mask);
                            3'd2: m_cmp[i][63:32] = apply_lanes(mt_old_cmp[63:32], data_wr_data, data_mask);
                            3'd3: begin
                                m_mtime[i][31:0] = apply_lanes(mt_old_time[31:0], data_wr_data, data_mask);
                                mt_time_wr = 1'b1;
                            end
                            3'd4: begin
                                m_mtime[i][63:32] = apply_lanes(mt_old_time[63:32], data_wr_data, data_mask);
                                mt_time_wr = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                if (mt_tick && !mt_time_wr) m_mtime[i] = m_mtime[i] + 64'd1;
                m_irq[i] = mt_irq_next;
                m_ack[i] = mt_acc;
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (seen_edge) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model_ack[%0d]", i), ack_v[i], m_ack[i]);
                check($sformatf("model_rd[%0d]", i), rd_of(i), m_rd[i]);
                check($sformatf("model_tmr[%0d]", i), tmr_v[i], m_irq[i]);
                check($sformatf("model_sw[%0d]", i), sw_v[i], m_msip[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus tasks: request at a negedge, accept at the next posedge,
    // ack observed at the following negedge.
    // ------------------------------------------------------------------
    task automatic bus_write(input int inst, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] mask);
        @(negedge clk);
        data_addr = addr; data_wr_data = wd; data_mask = mask;
        data_wr_en = 1'b1; data_req = 1'b1;
        @(negedge clk);
        check($sformatf("wr_ack@%h", addr), ack_v[inst], 1'b1);
        check($sformatf("wr_rd0@%h", addr), rd_of(inst), 32'd0);
        data_req = 1'b0; data_wr_en = 1'b0;
    endtask

    task automatic bus_read(input int inst, input logic [31:0] addr, output logic [31:0] rd);
        @(negedge clk);
        data_addr = addr; data_wr_en = 1'b0; data_mask = 4'hF; data_req = 1'b1;
        @(negedge clk);
        check($sformatf("rd_ack@%h", addr), ack_v[inst], 1'b1);
        rd = rd_of(inst);
        data_req = 1'b0;
    endtask

    logic [31:0] r, r1, r2;
    int n;

    initial begin
        rstz = 1'b0; data_addr = '0; data_wr_data = '0; data_mask = '0;
        data_wr_en = 1'b0; data_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack_v, 2'b00);
        check("rst_tmr", tmr_v, 2'b00);
        check("rst_sw", sw_v, 2'b00);
        check("rst_rd", rd_a, 32'd0);
        rstz = 1'b1;

        // Idle, then mtime must have advanced by the number of edges
        repeat (10) @(negedge clk);
        bus_read(0, 32'h0000_100C, r);
        check("mtime_after_idle_ge11", (r >= 32'd11), 1'b1);
        bus_read(0, 32'h0000_1008, r);
        check("cmp_hi_reset", r, 32'hFFFF_FFFF);
        check("irq_idle", tmr_v, 2'b00);

        // Timer interrupt rise/fall
        bus_write(0, 32'h0000_100C, 32'd0, 4'hF);
        bus_write(0, 32'h0000_1004, 32'd20, 4'hF);
        bus_write(0, 32'h0000_1008, 32'd0, 4'hF);
        n = 0;
        while (!tmr_v[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("irq_rise_delay", n, 17);
        bus_write(0, 32'h0000_1004, 32'hFFFF_FFFF, 4'hF);
        check("irq_still_high_at_ack", tmr_v[0], 1'b1);
        @(negedge clk);
        check("irq_fall", tmr_v[0], 1'b0);

        // Carry from lo to hi
        bus_write(0, 32'h0000_1010, 32'd0, 4'hF);
        bus_write(0, 32'h0000_100C, 32'hFFFF_FFFE, 4'hF);
        @(negedge clk);
        bus_read(0, 32'h0000_100C, r);
        check("carry_lo", r, 32'd0);
        bus_read(0, 32'h0000_1010, r);
        check("carry_hi", r, 32'd1);

        // 64-bit wrap
        bus_write(0, 32'h0000_1010, 32'hFFFF_FFFF, 4'hF);
        bus_write(0, 32'h0000_100C, 32'hFFFF_FFFF, 4'hF);
        bus_read(0, 32'h0000_100C, r);
        check("wrap_lo", r, 32'd0);
        bus_read(0, 32'h0000_1010, r);
        check("wrap_hi", r, 32'd0);

        // msip with byte mask, then mask-0 no-op write
        bus_write(0, 32'h0000_1000, 32'h5, 4'b0001);
        check("sw_set", sw_v[0], 1'b1);
        bus_read(0, 32'h0000_1000, r);
        check("msip_read", r, 32'd1);
        bus_write(0, 32'h0000_1000, 32'h0, 4'b0000);
        check("sw_mask0", sw_v[0], 1'b1);
        bus_read(0, 32'h0000_1000, r);
        check("msip_mask0_read", r, 32'd1);

        // TICK_DIV=4: one increment per four cycles
        bus_read(1, 32'h0000_300C, r1);
        repeat (2) @(negedge clk);
        bus_read(1, 32'h0000_300C, r2);
        check("div4_step", r2 - r1, 32'd1);

        // Write mtime lo in a tick cycle: no increment that cycle
        while ((edge_cnt + 2) % 4 != 0) @(negedge clk);
        bus_write(1, 32'h0000_300C, 32'h100, 4'hF);
        bus_read(1, 32'h0000_300C, r);
        check("tick_write_holds", r, 32'h100);
        repeat (2) @(negedge clk);
        bus_read(1, 32'h0000_300C, r);
        check("tick_write_next", r, 32'h101);

        // Unselected address held for 5 cycles: no ack
        @(negedge clk);
        data_addr = 32'h0000_2000; data_wr_en = 1'b0; data_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("unsel_no_ack", ack_v, 2'b00);
        end
        data_req = 1'b0;

        // Reserved offset reads 0
        bus_read(0, 32'h0000_1018, r);
        check("off6_read", r, 32'd0);

        // Reset asserted during RESP of a write
        @(negedge clk);
        data_addr = 32'h0000_1004; data_wr_data = 32'd5; data_mask = 4'hF;
        data_wr_en = 1'b1; data_req = 1'b1;
        @(negedge clk);
        rstz = 1'b0; data_req = 1'b0; data_wr_en = 1'b0;
        @(negedge clk);
        check("rst_resp_ack", ack_v[0], 1'b0);
        rstz = 1'b1;
        bus_read(0, 32'h0000_1004, r);
        check("rst_resp_cmp", r, 32'hFFFF_FFFF);

        // Reset sampled at the accept edge: write dropped, no ack
        @(negedge clk);
        data_addr = 32'h0000_1000; data_wr_data = 32'd1; data_mask = 4'hF;
        data_wr_en = 1'b1; data_req = 1'b1; rstz = 1'b0;
        @(negedge clk);
        check("rst_acc_ack", ack_v[0], 1'b0);
        check("rst_acc_sw", sw_v[0], 1'b0);
        data_req = 1'b0; data_wr_en = 1'b0; rstz = 1'b1;
        bus_read(0, 32'h0000_1000, r);
        check("rst_acc_msip", r, 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
